hyperbus_burst_splitter: RTL and testbench

- Upstream neighbour of the HyperBus PHY transfer interface. Accepts one linear word-granular transfer request at a time and emits a sequence of hyper_tf_t-shaped chunk descriptors to the PHY.
- Each chunk obeys three caps:
  - the configured maximum burst length (derived from t_burst_max so CS# low time t_CSM is respected);
  - an aligned address boundary;
  - the burst-field width.
- Downstream receives only legal chunks; a last flag lets the front-end track completion.

---
 rtl/hyperbus_burst_splitter.sv | 128 ++++++++++++
 tb/tb_hyperbus_burst_splitter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_burst_splitter.sv
// Splits one linear word-granular transfer into HyperBus-legal chunks bounded by the
// configured burst cap, an aligned address boundary and the burst field width.
module hyperbus_burst_splitter #(
  parameter int unsigned BurstWidth    = 15,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned BoundaryBytes = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           cfg_max_words_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_write_i,
  input  logic                  in_addr_space_i,
  input  logic                  in_burst_type_i,
  input  logic [31:0]           in_addr_i,
  input  logic [LenWidth-1:0]   in_len_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_write_o,
  output logic                  out_addr_space_o,
  output logic                  out_burst_type_o,
  output logic [31:0]           out_addr_o,
  output logic [BurstWidth-1:0] out_burst_o,
  output logic                  out_last_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned CW   = LenWidth + 1;
  localparam int unsigned BndW = $clog2(BoundaryBytes);
  localparam logic [CW-1:0] MaxBurst = CW'((2 ** BurstWidth) - 1);
  localparam logic [CW-1:0] BndWords = CW'(BoundaryBytes / 2);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [15:0]         cfg_q, cfg_d;
  logic                write_q, write_d;
  logic                space_q, space_d;
  logic                btype_q, btype_d;
  logic                err_q, err_d;

  logic [CW-1:0] cap_cfg, to_bnd, chunk;

  // Chunk size is the minimum of all caps, evaluated one bit wider than the length.
  always_comb begin
    cap_cfg = (cfg_q == '0) ? '1 : CW'(cfg_q);
    to_bnd  = BndWords - CW'(addr_q[BndW-1:1]);
    chunk   = CW'(rem_q);
    if (cap_cfg < chunk)  chunk = cap_cfg;
    if (to_bnd < chunk)   chunk = to_bnd;
    if (MaxBurst < chunk) chunk = MaxBurst;
  end

  always_comb begin
    in_ready_o       = (state_q == StIdle);
    out_valid_o      = (state_q == StIssue);
    busy_o           = (state_q == StIssue);
    err_o            = err_q;
    out_write_o      = write_q;
    out_addr_space_o = space_q;
    out_burst_type_o = btype_q;
    out_addr_o       = addr_q;
    out_burst_o      = chunk[BurstWidth-1:0];
    out_last_o       = (chunk == CW'(rem_q));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cfg_d   = cfg_q;
    write_d = write_q;
    space_d = space_q;
    btype_d = btype_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          addr_d  = in_addr_i & ~32'h1;
          rem_d   = in_len_i;
          cfg_d   = cfg_max_words_i;
          write_d = in_write_i;
          space_d = in_addr_space_i;
          btype_d = in_burst_type_i;
          if (in_len_i == '0) err_d = 1'b1;
          else                state_d = StIssue;
        end
      end
      StIssue: begin
        if (out_ready_i) begin
          // Address wraps naturally at 2^32.
          addr_d = addr_q + (32'(chunk[BurstWidth-1:0]) << 1);
          rem_d  = rem_q - chunk[LenWidth-1:0];
          if (out_last_o) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      cfg_q   <= '0;
      write_q <= 1'b0;
      space_q <= 1'b0;
      btype_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cfg_q   <= cfg_d;
      write_q <= write_d;
      space_q <= space_d;
      btype_q <= btype_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Randomized bench for hyperbus_burst_splitter; expected chunk lists come from a
// plain arithmetic model of the min-of-caps rule.
module tb_hyperbus_burst_splitter;

  localparam int unsigned Bnd = 1024;
  localparam int unsigned HardCap = 32767;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] cfg_max_words_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_write_i;
  logic        in_addr_space_i;
  logic        in_burst_type_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_len_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_write_o;
  logic        out_addr_space_o;
  logic        out_burst_type_o;
  logic [31:0] out_addr_o;
  logic [14:0] out_burst_o;
  logic        out_last_o;
  logic        err_o;
  logic        busy_o;

  hyperbus_burst_splitter dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_max_words_i  (cfg_max_words_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_write_i       (in_write_i),
    .in_addr_space_i  (in_addr_space_i),
    .in_burst_type_i  (in_burst_type_i),
    .in_addr_i        (in_addr_i),
    .in_len_i         (in_len_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_write_o      (out_write_o),
    .out_addr_space_o (out_addr_space_o),
    .out_burst_type_o (out_burst_type_o),
    .out_addr_o       (out_addr_o),
    .out_burst_o      (out_burst_o),
    .out_last_o       (out_last_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    int unsigned burst;
    bit          last;
  } chunk_t;

  chunk_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: each chunk is the smallest of remaining, cfg cap, words to boundary, hard cap.
  task automatic build_model(input logic [31:0] addr, input int unsigned len,
                             input int unsigned cfg);
    logic [31:0] a;
    longint unsigned r, c, wtb;
    chunk_t e;
    exp_q.delete();
    a = addr & ~32'h1;
    r = len;
    while (r > 0) begin
      c = r;
      if (cfg != 0 && cfg < c) c = cfg;
      wtb = (Bnd - (a % Bnd)) / 2;
      if (wtb < c) c = wtb;
      if (HardCap < c) c = HardCap;
      e.addr  = a;
      e.burst = int'(c);
      e.last  = (c == r);
      exp_q.push_back(e);
      a = a + 32'(2 * c);
      r = r - c;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall five cycles on the second chunk
  task automatic run_req(input logic [31:0] addr, input int unsigned len,
                         input logic [15:0] cfg, input int mode);
    chunk_t e;
    logic w, sp, bt, rdy, held;
    logic [31:0] p_addr;
    logic [14:0] p_burst;
    logic p_last;
    int unsigned budget, idx, stall;
    w  = 1'($urandom_range(0, 1));
    sp = 1'($urandom_range(0, 1));
    bt = 1'($urandom_range(0, 1));
    build_model(addr, len, cfg);
    check_eq("idle_ready", in_ready_o, 1);
    in_valid_i      = 1'b1;
    in_addr_i       = addr;
    in_len_i        = len;
    cfg_max_words_i = cfg;
    in_write_i      = w;
    in_addr_space_i = sp;
    in_burst_type_i = bt;
    out_ready_i     = 1'($urandom_range(0, 1));
    step();
    in_valid_i      = 1'b0;
    in_addr_i       = $urandom;
    in_len_i        = $urandom;
    cfg_max_words_i = 16'($urandom);
    in_write_i      = ~w;
    if (len == 0) begin
      check_eq("zero_err", err_o, 1);
      check_eq("zero_valid", out_valid_o, 0);
      check_eq("zero_ready", in_ready_o, 1);
      step();
      check_eq("zero_err_pulse", err_o, 0);
      check_eq("zero_valid2", out_valid_o, 0);
      return;
    end
    held   = 1'b0;
    idx    = 0;
    stall  = 0;
    budget = 4 * len + 40;
    p_addr = '0; p_burst = '0; p_last = 1'b0;
    while (exp_q.size() > 0) begin
      if (budget == 0) begin
        check_eq("timeout_left", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      budget--;
      check_eq("valid", out_valid_o, 1);
      check_eq("busy", busy_o, 1);
      check_eq("ready_low", in_ready_o, 0);
      check_eq("err_quiet", err_o, 0);
      if (held) begin
        check_eq("stable_addr", out_addr_o, p_addr);
        check_eq("stable_burst", out_burst_o, p_burst);
        check_eq("stable_last", out_last_o, p_last);
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 9) < 7);
      else if (idx == 1 && stall < 5) begin rdy = 1'b0; stall++; end
      else rdy = 1'b1;
      out_ready_i = rdy;
      if (rdy) begin
        e = exp_q.pop_front();
        check_eq("addr", out_addr_o, e.addr);
        check_eq("burst", out_burst_o, e.burst);
        check_eq("last", out_last_o, e.last);
        check_eq("write", out_write_o, w);
        check_eq("space", out_addr_space_o, sp);
        check_eq("btype", out_burst_type_o, bt);
        idx++;
        held = 1'b0;
      end else begin
        held    = 1'b1;
        p_addr  = out_addr_o;
        p_burst = out_burst_o;
        p_last  = out_last_o;
      end
      step();
    end
    out_ready_i = 1'b0;
    check_eq("done_valid", out_valid_o, 0);
    check_eq("done_ready", in_ready_o, 1);
    check_eq("done_busy", busy_o, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    int unsigned rl;
    logic [15:0] rc;
    rst_i = 1'b1;
    cfg_max_words_i = '0;
    in_valid_i = 1'b0;
    in_write_i = 1'b0;
    in_addr_space_i = 1'b0;
    in_burst_type_i = 1'b0;
    in_addr_i = '0;
    in_len_i = '0;
    out_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check_eq("rst_valid", out_valid_o, 0);
    check_eq("rst_ready", in_ready_o, 1);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_addr", out_addr_o, 0);

    run_req(32'h0, 8, 16'd0, 0);
    run_req(32'h3F8, 16, 16'd0, 0);
    run_req(32'h0, 1000, 16'd350, 0);
    run_req(32'h0, 1000, 16'd350, 2);
    run_req(32'h0, 0, 16'd0, 0);
    run_req(32'hFFFF_FFFC, 4, 16'd0, 1);
    run_req(32'h0000_0123, 700, 16'd0, 1);

    // Reset while the second of three chunks is pending.
    in_valid_i = 1'b1; in_addr_i = 32'h0; in_len_i = 30; cfg_max_words_i = 16'd10;
    step();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    check_eq("rst_mid_burst0", out_burst_o, 10);
    step();
    check_eq("rst_mid_addr1", out_addr_o, 32'h14);
    out_ready_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_eq("rst_mid_valid", out_valid_o, 0);
    check_eq("rst_mid_ready", in_ready_o, 1);
    check_eq("rst_mid_err", err_o, 0);
    check_eq("rst_mid_busy", busy_o, 0);
    run_req(32'h0000_0040, 30, 16'd10, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FC00 | 32'($urandom_range(0, 1023));
      rl = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 400);
      case ($urandom_range(0, 2))
        0:       rc = 16'd0;
        1:       rc = 16'($urandom_range(1, 64));
        default: rc = 16'($urandom_range(100, 600));
      endcase
      run_req(ra, rl, rc, $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
